// File: rtl/integrator_decim.sv
// rtl/integrator_decim.sv - clamped integrator with decimating one-deep output stage
module integrator_decim #(
    parameter int OUT_WIDTH    = 8,
    parameter int DECIM_FACTOR = 50
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [1:0]           data_i,
    input  logic                 valid_i,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 ovf_o,
    output logic                 sat_o
);
    localparam int AW = OUT_WIDTH + 2;
    localparam int CW = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
    localparam logic signed [AW-1:0] ACC_MAX  = AW'((1 << OUT_WIDTH) - 1);
    localparam logic [CW-1:0]        CNT_LAST = CW'(DECIM_FACTOR - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] acc_next;
    logic [CW-1:0]        cnt;
    logic                 accept;
    logic                 capture;
    logic                 clamp;
    state_t               state;
    state_t               state_next;
    logic [OUT_WIDTH-1:0] data_next;
    logic                 drop;

    assign accept  = en_i & valid_i;
    assign capture = accept & (cnt == CNT_LAST);

    // Stored acc is always in range, so a 2-bit step can never wrap the AW-bit sum.
    always_comb begin
        sum      = acc + $signed({{OUT_WIDTH{data_i[1]}}, data_i});
        acc_next = sum;
        clamp    = 1'b0;
        if (sum < 0) begin
            acc_next = '0;
            clamp    = 1'b1;
        end else if (sum > ACC_MAX) begin
            acc_next = ACC_MAX;
            clamp    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc <= '0;
            cnt <= '0;
        end else if (!en_i) begin
            acc <= '0;
            cnt <= '0;
        end else if (valid_i) begin
            acc <= acc_next;
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        data_next  = data_o;
        drop       = 1'b0;
        if (!en_i) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (capture) begin
                        state_next = FULL;
                        data_next  = acc_next[OUT_WIDTH-1:0];
                    end
                end
                FULL: begin
                    if (ready_i) begin
                        if (capture) data_next = acc_next[OUT_WIDTH-1:0];
                        else         state_next = EMPTY;
                    end else if (capture) begin
                        drop = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= EMPTY;
            data_o <= '0;
            ovf_o  <= 1'b0;
            sat_o  <= 1'b0;
        end else begin
            state  <= state_next;
            data_o <= data_next;
            ovf_o  <= ovf_o | drop;
            sat_o  <= sat_o | (accept & clamp);
        end
    end

    assign valid_o = (state == FULL);
endmodule

// File: tb/tb_integrator_decim.sv
// tb/tb_integrator_decim.sv - randomized and directed checks of integrator_decim against a reference model
module tb_integrator_decim;
    localparam int OW  = 8;
    localparam int DF  = 4;
    localparam int MAX = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [1:0]    din = 2'b00;
    logic          vin = 1'b0;
    logic          ready = 1'b0;
    logic [OW-1:0] dout;
    logic          vout;
    logic          ovf;
    logic          sat;

    int checks = 0;
    int failures = 0;

    int m_acc, m_cnt, m_dout;
    bit m_full, m_ovf, m_sat;

    integrator_decim #(.OUT_WIDTH(OW), .DECIM_FACTOR(DF)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .data_i(din), .valid_i(vin),
        .data_o(dout), .valid_o(vout), .ready_i(ready), .ovf_o(ovf), .sat_o(sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_acc = 0; m_cnt = 0; m_dout = 0;
        m_full = 0; m_ovf = 0; m_sat = 0;
    endfunction

    // Behavioural view: running clamped sum, every DF-th accepted sample offered to a one-slot buffer.
    function automatic void model_edge(input bit e, input bit v, input int d, input bit r);
        bit cap = 0;
        if (!e) begin
            m_acc = 0; m_cnt = 0; m_full = 0;
            return;
        end
        if (v) begin
            m_acc = m_acc + d;
            if (m_acc < 0)   begin m_acc = 0;   m_sat = 1; end
            if (m_acc > MAX) begin m_acc = MAX; m_sat = 1; end
            m_cnt++;
            if (m_cnt == DF) begin cap = 1; m_cnt = 0; end
        end
        if (m_full && !r) begin
            if (cap) m_ovf = 1;
        end else if (cap) begin
            m_full = 1; m_dout = m_acc;
        end else begin
            m_full = 0;
        end
    endfunction

    task automatic compare(input string tag);
        check({tag, ".data"},  int'(dout), m_dout);
        check({tag, ".valid"}, int'(vout), int'(m_full));
        check({tag, ".ovf"},   int'(ovf),  int'(m_ovf));
        check({tag, ".sat"},   int'(sat),  int'(m_sat));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge(en, vin, int'($signed(din)), ready);
        #1;
        compare(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        compare(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic samples(input int n, input logic [1:0] d, input string tag);
        for (int i = 0; i < n; i++) begin
            vin = 1'b1; din = d;
            step(tag);
        end
        vin = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        compare("reset");
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b1; ready = 1'b1;

        // four +1 with ready high: one-cycle valid pulse of 4, then 8
        samples(3, 2'b01, "ramp");
        check("ramp.pre_valid", int'(vout), 0);
        samples(1, 2'b01, "ramp");
        check("ramp.first", int'(dout), 4);
        check("ramp.first_valid", int'(vout), 1);
        step("ramp.idle");
        check("ramp.pulse_end", int'(vout), 0);
        samples(4, 2'b01, "ramp2");
        check("ramp.second", int'(dout), 8);

        // async reset while FULL holding 3
        do_reset("r1");
        ready = 1'b0;
        samples(3, 2'b01, "to3");
        samples(1, 2'b00, "to3");
        check("to3.data", int'(dout), 3);
        check("to3.valid", int'(vout), 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("async.data", int'(dout), 0);
        check("async.valid", int'(vout), 0);
        check("async.ovf", int'(ovf), 0);
        check("async.sat", int'(sat), 0);
        @(posedge clk); #1; rst = 1'b0;

        // underflow then saturate high
        ready = 1'b1;
        samples(1, 2'b11, "under");
        check("under.sat", int'(sat), 1);
        samples(260, 2'b01, "over");
        check("over.data", int'(dout), 255);
        check("over.sat", int'(sat), 1);

        // backpressure drop
        do_reset("r2");
        ready = 1'b0;
        samples(8, 2'b01, "bp");
        check("bp.data", int'(dout), 4);
        check("bp.ovf", int'(ovf), 1);
        check("bp.valid", int'(vout), 1);
        ready = 1'b1;
        step("bp.drain");
        check("bp.drained", int'(vout), 0);
        check("bp.held", int'(dout), 4);

        // enable dropout mid-window
        do_reset("r3");
        samples(2, 2'b01, "en");
        en = 1'b0;
        step("en.off");
        en = 1'b1;
        samples(4, 2'b01, "en");
        check("en.data", int'(dout), 4);

        // back-to-back capture with no bubble
        do_reset("r4");
        ready = 1'b0;
        samples(7, 2'b01, "b2b");
        ready = 1'b1;
        samples(1, 2'b01, "b2b");
        check("b2b.data", int'(dout), 8);
        check("b2b.valid", int'(vout), 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset("rnd.rst");
            en    = ($urandom_range(0, 19) != 0);
            vin   = ($urandom_range(0, 3) != 0);
            din   = 2'($urandom);
            ready = ($urandom_range(0, 2) != 0);
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
